// File: rtl/piso_shift_reg_if.sv
// piso_shift_reg_if: parallel load port plus serial unload port of the PISO register.
// slave is the register side, master is the producer/consumer side.
interface piso_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] i;
    logic             i_valid;
    logic             i_ready;
    logic             o;
    logic             o_valid;
    logic             o_ready;
    logic             o_last;

    modport master (
        output i,
        output i_valid,
        input  i_ready,
        input  o,
        input  o_valid,
        output o_ready,
        input  o_last
    );

    modport slave (
        input  i,
        input  i_valid,
        output i_ready,
        output o,
        output o_valid,
        input  o_ready,
        output o_last
    );
endinterface

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: loads a WIDTH-bit word over valid/ready and unloads it one bit per serial beat.
// Optional zero-bubble word chaining is enabled by defining PISO_SHIFT_REG_BACK_TO_BACK_EN.
module piso_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      MSB_FIRST = 0,
    parameter logic [WIDTH-1:0] INIT      = '0
) (
    input logic             real_clk,
    input logic             reset,
    piso_shift_reg_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             o_last_q;
    logic             o_last_d;

    logic             in_ready_c;
    logic             out_valid_c;
    logic             load_c;
    logic             xfer_c;
    logic [WIDTH-1:0] shifted_c;

`ifdef PISO_SHIFT_REG_BACK_TO_BACK_EN
    // Ready reopens on the final accepted beat so the next word follows with no bubble
    assign in_ready_c = (state_q == IDLE) || (o_last_q && bus.o_ready);
`else
    logic i_ready_q;
    logic i_ready_d;

    assign in_ready_c = i_ready_q;
`endif

    assign out_valid_c = (state_q == SHIFT);
    assign load_c      = bus.i_valid && in_ready_c;
    assign xfer_c      = out_valid_c && bus.o_ready;

    // Move the next bit toward the output end, zero-filling the vacated position
    assign shifted_c = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};

    assign bus.i_ready = in_ready_c;
    assign bus.o_valid = out_valid_c;
    assign bus.o       = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign bus.o_last  = o_last_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (load_c) begin
                    shreg_d = bus.i;
                    count_d = CNT_LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer_c) begin
                    if (count_q != '0) begin
                        shreg_d = shifted_c;
                        count_d = count_q - CNT_W'(1);
                    end else if (load_c) begin
                        // Only reachable when ready can open during the final beat
                        shreg_d = bus.i;
                        count_d = CNT_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        o_last_d = (state_d == SHIFT) && (count_d == '0);
`ifndef PISO_SHIFT_REG_BACK_TO_BACK_EN
        i_ready_d = (state_d == IDLE);
`endif
    end

    // State and datapath registers; the shift register keeps its value after the last bit
    always_ff @(posedge real_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= INIT;
            count_q   <= '0;
            o_last_q  <= 1'b0;
`ifndef PISO_SHIFT_REG_BACK_TO_BACK_EN
            i_ready_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            count_q   <= count_d;
            o_last_q  <= o_last_d;
`ifndef PISO_SHIFT_REG_BACK_TO_BACK_EN
            i_ready_q <= i_ready_d;
`endif
        end
    end
endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: LSB-first and MSB-first instances driven in lockstep, checked every
// cycle against a word/bit-index model, with literal word expectations for directed cases.
`timescale 1ns/1ps
module tb_piso_shift_reg;
    localparam int W       = 8;
    localparam int TIMEOUT = 200;
    localparam logic [W-1:0] INIT_L = 8'h5A;
    localparam logic [W-1:0] INIT_M = 8'hC3;

    logic         real_clk  = 1'b0;
    logic         reset     = 1'b1;
    logic [W-1:0] s_i       = '0;
    logic         s_i_valid = 1'b0;
    logic         s_o_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int tick   = 0;

    always #5 real_clk = ~real_clk;

    piso_shift_reg_if #(.WIDTH(W)) bus_l ();
    piso_shift_reg_if #(.WIDTH(W)) bus_m ();

    assign bus_l.i       = s_i;
    assign bus_l.i_valid = s_i_valid;
    assign bus_l.o_ready = s_o_ready;
    assign bus_m.i       = s_i;
    assign bus_m.i_valid = s_i_valid;
    assign bus_m.o_ready = s_o_ready;

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(0), .INIT(INIT_L)) dut_l (
        .real_clk (real_clk),
        .reset    (reset),
        .bus      (bus_l)
    );

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1), .INIT(INIT_M)) dut_m (
        .real_clk (real_clk),
        .reset    (reset),
        .bus      (bus_m)
    );

    logic act_v [2];
    logic act_o [2];
    logic act_last [2];
    logic act_rdy [2];
    assign act_v[0]    = bus_l.o_valid;
    assign act_o[0]    = bus_l.o;
    assign act_last[0] = bus_l.o_last;
    assign act_rdy[0]  = bus_l.i_ready;
    assign act_v[1]    = bus_m.o_valid;
    assign act_o[1]    = bus_m.o;
    assign act_last[1] = bus_m.o_last;
    assign act_rdy[1]  = bus_m.i_ready;

    // Model: the word in flight and how many of its bits are still to be sent
    int           rem [2];
    logic [W-1:0] mword [2];
    bit           o_known [2];
    int           loads [2];
    int           dones [2];
    int           done_cyc [2];
    int           period [2];
    int           cyc = 0;
    logic [W-1:0] mcap [2];
    logic [W-1:0] mdone_word [2];
    logic [W-1:0] dcap [2];
    logic [W-1:0] ddone_word [2];
    int           dk [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; mword[d] = '0; o_known[d] = 1'b0; loads[d] = 0; dones[d] = 0;
            done_cyc[d] = 0; period[d] = 0; mcap[d] = '0; mdone_word[d] = '0;
            dcap[d] = '0; ddone_word[d] = '0; dk[d] = 0;
        end
    end

    function automatic string nm(input int d);
        return (d == 0) ? "lsb" : "msb";
    endfunction

    // Word bit sent as the k-th serial beat
    function automatic int send_idx(input int d, input int k);
        return (d == 1) ? (W - 1 - k) : k;
    endfunction

    function automatic logic init_bit(input int d);
        logic [W-1:0] v;
        v = (d == 0) ? INIT_L : INIT_M;
        return (d == 0) ? v[0] : v[W-1];
    endfunction

    function automatic logic exp_ready(input int d);
`ifdef PISO_SHIFT_REG_BACK_TO_BACK_EN
        return (rem[d] == 0) || (rem[d] == 1 && s_o_ready);
`else
        return (rem[d] == 0);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare outputs mid-cycle, then advance the model with the inputs the next edge samples
    always @(negedge real_clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            logic rdy;
            int   k;
            rdy = exp_ready(d);
            if (chk_en) begin
                check($sformatf("%s o_valid", nm(d)), 64'(act_v[d]), 64'(rem[d] > 0));
                check($sformatf("%s i_ready", nm(d)), 64'(act_rdy[d]), 64'(rdy));
                if (rem[d] > 0) begin
                    check($sformatf("%s o", nm(d)), 64'(act_o[d]),
                          64'(mword[d][send_idx(d, W - rem[d])]));
                    check($sformatf("%s o_last", nm(d)), 64'(act_last[d]), 64'(rem[d] == 1));
                end else begin
                    check($sformatf("%s o_last idle", nm(d)), 64'(act_last[d]), 64'(0));
                    if (o_known[d])
                        check($sformatf("%s o reset value", nm(d)), 64'(act_o[d]), 64'(init_bit(d)));
                end
            end

            if (reset) begin
                dk[d]   = 0;
                dcap[d] = '0;
            end else if (act_v[d] === 1'b1 && s_o_ready === 1'b1) begin
                dcap[d][dk[d]] = act_o[d];
                if (act_last[d] === 1'b1) begin
                    ddone_word[d] = dcap[d];
                    dcap[d]       = '0;
                    dk[d]         = 0;
                end else if (dk[d] < W - 1) begin
                    dk[d]++;
                end
            end

            if (reset) begin
                rem[d]     = 0;
                o_known[d] = 1'b1;
            end else begin
                if (rem[d] > 0 && s_o_ready) begin
                    k = W - rem[d];
                    mcap[d][k] = mword[d][send_idx(d, k)];
                    rem[d]--;
                    if (rem[d] == 0) begin
                        mdone_word[d] = mcap[d];
                        dones[d]++;
                        period[d]   = cyc - done_cyc[d];
                        done_cyc[d] = cyc;
                        o_known[d]  = 1'b0;
                    end
                end
                if (s_i_valid && rdy) begin
                    mword[d] = s_i;
                    rem[d]   = W;
                    mcap[d]  = '0;
                    loads[d]++;
                end
            end
        end
    end

    // One cycle; mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
    task automatic step(input int mode);
        @(posedge real_clk);
        #1;
        tick++;
        case (mode)
            0:       s_o_ready = 1'b1;
            1:       s_o_ready = (tick % 3 == 0);
            default: s_o_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_load(input int mode);
        int l0;
        bit ok;
        l0 = loads[0];
        ok = 1'b0;
        for (int n = 0; n < TIMEOUT; n++) begin
            step(mode);
            if (loads[0] != l0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("load timeout", 64'(0), 64'(1));
    endtask

    task automatic load_word(input logic [W-1:0] w, input int mode);
        s_i       = w;
        s_i_valid = 1'b1;
        wait_load(mode);
        s_i_valid = 1'b0;
    endtask

    task automatic wait_done(input int mode, input int target);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < TIMEOUT; n++) begin
            if (dones[0] >= target) begin
                ok = 1'b1;
                break;
            end
            step(mode);
        end
        if (!ok) check("drain timeout", 64'(0), 64'(1));
    endtask

    task automatic expect_word(input string name, input logic [W-1:0] lit_l, input logic [W-1:0] lit_m);
        check({name, " model lsb word"}, 64'(mdone_word[0]), 64'(lit_l));
        check({name, " model msb word"}, 64'(mdone_word[1]), 64'(lit_m));
        check({name, " dut lsb word"}, 64'(ddone_word[0]), 64'(lit_l));
        check({name, " dut msb word"}, 64'(ddone_word[1]), 64'(lit_m));
    endtask

    initial begin
        repeat (2) @(posedge real_clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (2) step(0);

        // Basic word, both bit orders
        load_word(8'hA5, 0);
        wait_done(0, dones[0] + 1);
        expect_word("a5", 8'hA5, 8'hA5);
        repeat (2) step(0);

        // Backpressure holds the current bit
        load_word(8'h0F, 1);
        wait_done(1, dones[0] + 1);
        expect_word("0f", 8'h0F, 8'hF0);
        repeat (2) step(0);

        // Reset after three bits drops the partial word
        load_word(8'hFF, 0);
        repeat (3) step(0);
        reset = 1'b1;
        step(0);
        reset = 1'b0;
        step(0);
        load_word(8'h01, 0);
        wait_done(0, dones[0] + 1);
        expect_word("after reset", 8'h01, 8'h80);
        repeat (2) step(0);

        // Reset and load in the same cycle: the word is refused
        s_i       = 8'hFF;
        s_i_valid = 1'b1;
        reset     = 1'b1;
        step(0);
        reset     = 1'b0;
        s_i_valid = 1'b0;
        repeat (2) step(0);

        // Two words with valid held high
        begin
            int d0;
            d0        = dones[0];
            s_i       = 8'h01;
            s_i_valid = 1'b1;
            wait_load(0);
            s_i = 8'h80;
            wait_load(0);
            s_i_valid = 1'b0;
            wait_done(0, d0 + 2);
            expect_word("second of pair", 8'h80, 8'h01);
`ifdef PISO_SHIFT_REG_BACK_TO_BACK_EN
            check("word period", 64'(period[0]), 64'(W));
`else
            check("word period", 64'(period[0]), 64'(W + 1));
`endif
        end
        repeat (2) step(0);

        // A new word offered mid-shift must not disturb the current one
        load_word(8'hA5, 0);
        s_i       = 8'h3C;
        s_i_valid = 1'b1;
        repeat (5) step(0);
        s_i_valid = 1'b0;
        wait_done(0, dones[0] + 1);
        expect_word("ignored mid-shift", 8'hA5, 8'hA5);

        // Randomised traffic, backpressure and occasional reset
        for (int n = 0; n < 800; n++) begin
            s_i       = W'($urandom);
            s_i_valid = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 63) == 0);
            step(2);
        end
        reset     = 1'b0;
        s_i_valid = 1'b0;
        repeat (3 * W) step(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parallel-in/serial-out register: accepts a WIDTH-bit word over a valid/ready handshake and unloads it one bit per accepted beat on a serial valid/ready port.
- It is the unload end of the register datapath. Words captured by the parallel registers are drained bit-serially toward narrow links and test ports.
- Single clock domain; no internal storage beyond one word plus a bit counter.

Parameters:
- WIDTH, 8: parallel word width; legal range 2..64.
- MSB_FIRST, 0: 0 = bit 0 is sent first; 1 = bit WIDTH-1 is sent first.
- INIT, 0: reset value of the internal shift register (WIDTH bits).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous reset, active-high.
- I  input  WIDTH  parallel word to load.
- I_VALID  input  1  I holds a word.
- I_READY  output  1  block accepts I this cycle.
- O  output  1  current serial bit.
- O_VALID  output  1  O holds a valid bit.
- O_READY  input  1  downstream accepts O this cycle.
- O_LAST  output  1  current bit is the final bit of the word.

Behaviour:
- Reset is fixed: one clock (CLK); RESET is synchronous and active-high. It is sampled only on the CLK rising edge.
- Reset values:
  - state = IDLE
  - shift register = INIT
  - count = 0
  - O_VALID = 0, O_LAST = 0
  - I_READY = 1 (from the first cycle after reset)
  - O = INIT[0] (MSB_FIRST=0) or INIT[WIDTH-1] (MSB_FIRST=1)
- Counter: count is $clog2(WIDTH) bits and holds the number of bits remaining minus 1.
- Load handshake: a word loads when I_VALID && I_READY at the clock edge.
- Serial handshake: a bit transfers when O_VALID && O_READY at the clock edge.
- State IDLE:
  - I_READY=1, O_VALID=0.
  - On load: shift register <= I, count <= WIDTH-1, go to SHIFT.
  - No load: hold everything.
- State SHIFT:
  - O_VALID=1, I_READY=0 (but see Optional Feature).
  - O = shift register bit 0 (MSB_FIRST=0) or bit WIDTH-1 (MSB_FIRST=1).
  - O_LAST = (count == 0).
- Transfer with count != 0:
  - Shift toward the output end. MSB_FIRST=0 shifts right; MSB_FIRST=1 shifts left.
  - Vacated bit is filled with 0.
  - count <= count-1; stay in SHIFT.
- Transfer with count == 0: go to IDLE. The shift register keeps its last value, and O is don't-care while O_VALID=0.
- Backpressure: O_READY=0 in SHIFT holds O, O_LAST, count and the shift register unchanged. There is no timeout.
- Latency:
  - First bit is presented the cycle after load.
  - A word takes exactly WIDTH serial beats.
  - Without the optional feature, the minimum word period is WIDTH+1 cycles.
- I_VALID while I_READY=0: ignored, with no side effect. Upstream holds the word.
- RESET mid-word: the partial word is discarded, no further bits are emitted, and all outputs take their reset values the next cycle.
- RESET and load in the same cycle: reset wins; the word is not accepted.
- I_READY in IDLE does not depend on I_VALID. O_VALID and O never depend combinationally on O_READY.

Optional Feature:
- Macro: PISO_SHIFT_REG_BACK_TO_BACK_EN.
- Defined:
  - In SHIFT, I_READY = (count==0) && O_READY (a combinational path from O_READY to I_READY).
  - If the last-bit transfer and a load coincide: shift register <= I, count <= WIDTH-1, stay in SHIFT.
  - The next word's first bit appears the next cycle, with no bubble; sustained throughput is one bit per cycle.
- Not defined:
  - I_READY=0 throughout SHIFT.
  - At least one IDLE cycle separates words, giving a minimum word period of WIDTH+1.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, RESET then I=8'hA5, I_VALID=1, O_READY=1 → O sequence 1,0,1,0,0,1,0,1. O_LAST is high only on the 8th beat, then O_VALID=0 and I_READY=1.
2. MSB_FIRST=1, I=8'hA5 → O sequence 1,0,1,0,0,1,0,1 read MSB first (bits 7..0). O_LAST is on beat 8.
3. I=8'h0F, O_READY toggling 1,0,0,1,… → each bit is held stable while O_READY=0. Exactly 8 transfers occur, giving 1,1,1,1,0,0,0,0.
4. RESET asserted after 3 bits of 8'hFF → next cycle O_VALID=0, I_READY=1. A new load of 8'h01 yields 1,0,0,0,0,0,0,0 with no residue.
5. I_VALID held high with words 8'h01, 8'h80, O_READY=1:
   - Without the macro: 8 bits, one idle cycle, 8 bits.
   - With PISO_SHIFT_REG_BACK_TO_BACK_EN: 16 consecutive valid beats; O_LAST on beats 8 and 16.
6. I_VALID=1 during SHIFT (macro undefined) with a different I → ignored; the serial output matches the originally loaded word.
